// File: rtl/jamma_joy_reader_pkg.sv
// Shared constants and the chain slot map for the JAMMA joystick reader.
// Contents:
//   NSLOTS, SLOT_W, JOY_W      frame geometry and player word width
//   J_RESET, J_COIN, J_START   well-known bit positions inside a player word
//   joy_pair_t                 both player words as one 24-bit payload
//   slot_map()                 chain slot -> bit position inside joy_pair_t
package jamma_joy_reader_pkg;

    localparam int unsigned NSLOTS = 26;
    localparam int unsigned SLOT_W = 5;
    localparam int unsigned JOY_W  = 12;
    localparam int unsigned POS_W  = 5;

    localparam int unsigned J_RESET = 11;
    localparam int unsigned J_AUX   = 10;
    localparam int unsigned J_COIN  = 9;
    localparam int unsigned J_START = 8;

    // Player 2 occupies the upper half so that j1 maps to bits [11:0].
    typedef struct packed {
        logic [JOY_W-1:0] j2;
        logic [JOY_W-1:0] j1;
    } joy_pair_t;

    typedef struct packed {
        logic             valid;
        logic [POS_W-1:0] pos;
    } slot_map_t;

    function automatic slot_map_t map_at(input logic p2, input int unsigned b);
        slot_map_t m;
        m.valid = 1'b1;
        m.pos   = p2 ? POS_W'(JOY_W + b) : POS_W'(b);
        return m;
    endfunction

    // Slots 0 and 1 carry no button and come back invalid.
    function automatic slot_map_t slot_map(input logic [SLOT_W-1:0] slot);
        slot_map_t m;
        m = '0;
        case (slot)
            5'd2:  m = map_at(1'b0, J_START);
            5'd3:  m = map_at(1'b0, 6);
            5'd4:  m = map_at(1'b0, 5);
            5'd5:  m = map_at(1'b0, 4);
            5'd6:  m = map_at(1'b0, 3);
            5'd7:  m = map_at(1'b0, 2);
            5'd8:  m = map_at(1'b0, 1);
            5'd9:  m = map_at(1'b0, 0);
            5'd10: m = map_at(1'b1, J_START);
            5'd11: m = map_at(1'b1, 6);
            5'd12: m = map_at(1'b1, 5);
            5'd13: m = map_at(1'b1, 4);
            5'd14: m = map_at(1'b1, 3);
            5'd15: m = map_at(1'b1, 2);
            5'd16: m = map_at(1'b1, 1);
            5'd17: m = map_at(1'b1, 0);
            5'd18: m = map_at(1'b1, J_AUX);
            5'd19: m = map_at(1'b1, J_RESET);
            5'd20: m = map_at(1'b1, J_COIN);
            5'd21: m = map_at(1'b1, 7);
            5'd22: m = map_at(1'b0, J_AUX);
            5'd23: m = map_at(1'b0, J_RESET);
            5'd24: m = map_at(1'b0, J_COIN);
            5'd25: m = map_at(1'b0, 7);
            default: m = '0;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/jamma_joy_reader_synchro.sv
// Two-flop synchroniser for a single asynchronous input.
// Ports:
//   clk, rst_n  destination clock, async active-low reset
//   d           asynchronous input
//   q           synchronised output (resets to RESET_VAL)
module jamma_joy_reader_synchro #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/jamma_joy_reader.sv
// Serial reader for the JAMMA adapter shift-register chain. Generates the
// chain clock and load strobe, captures one NSLOTS-slot frame, and publishes
// each button bit only after it reads the same in two consecutive frames.
// Ports:
//   clk, rst_n    pixel clock, async active-low reset
//   joy_data      serial data from the chain (asynchronous)
//   joy_clk       chain shift clock, CLK_DIV clk per half period
//   joy_load_n    chain parallel load, low for the whole of slot 0
//   joy1, joy2    debounced active-low player words
//   frame_done    one-cycle pulse per committed frame
module jamma_joy_reader
    import jamma_joy_reader_pkg::*;
#(
    parameter int unsigned CLK_DIV = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             joy_data,
    output logic             joy_clk,
    output logic             joy_load_n,
    output logic [JOY_W-1:0] joy1,
    output logic [JOY_W-1:0] joy2,
    output logic             frame_done
);

    localparam int unsigned DIV_W = 8;

    logic [DIV_W-1:0]  div_cnt;
    logic [SLOT_W-1:0] slot;
    logic [SLOT_W-1:0] slot_next_c;
    logic              data_s;
    logic              div_wrap_c;
    logic              tick_c;
    logic              last_tick;
    slot_map_t         map_c;
    joy_pair_t         raw;
    joy_pair_t         prev;
    joy_pair_t         pub;
    logic [2*JOY_W-1:0] stable_c;
    logic [2*JOY_W-1:0] commit_c;

    jamma_joy_reader_synchro #(.RESET_VAL(1'b1)) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (joy_data),
        .q     (data_s)
    );

    // Divider wrap toggles joy_clk; the low->high toggle is the slot tick.
    assign div_wrap_c = (div_cnt == DIV_W'(CLK_DIV - 1));
    assign tick_c     = div_wrap_c && !joy_clk;
    assign map_c      = slot_map(slot);

    always_comb begin
        slot_next_c = slot;
        if (tick_c) begin
            slot_next_c = (slot == SLOT_W'(NSLOTS - 1)) ? '0 : slot + SLOT_W'(1);
        end
    end

    // A bit follows the new frame only where both frames agree, else it holds.
    assign stable_c = ~(raw ^ prev);
    assign commit_c = (stable_c & raw) | (~stable_c & pub);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt    <= '0;
            joy_clk    <= 1'b0;
            slot       <= '0;
            joy_load_n <= 1'b1;
            raw        <= '1;
            prev       <= '1;
            pub        <= '1;
            last_tick  <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            div_cnt <= div_wrap_c ? '0 : div_cnt + DIV_W'(1);
            if (div_wrap_c) begin
                joy_clk <= !joy_clk;
            end
            slot <= slot_next_c;
            // Driven from the next slot so load is low exactly while slot==0.
            joy_load_n <= (slot_next_c != '0);
            if (tick_c && map_c.valid) begin
                raw[map_c.pos] <= data_s;
            end
            last_tick  <= tick_c && (slot == SLOT_W'(NSLOTS - 1));
            frame_done <= last_tick;
            if (last_tick) begin
                prev <= raw;
                pub  <= commit_c;
            end
        end
    end

    assign joy1 = pub.j1;
    assign joy2 = pub.j2;

endmodule
